// File: rtl/if_fetch_unit.sv
// ============================================================================
//  Module      : if_fetch_unit
//  Description : IF-stage controller: owns the PC, picks branch/jump/sequential
//                next PC and loads the IF/ID register under stall/flush/halt.
//                Optional bubble counter enabled by IF_BUBBLE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        stall,
  input  logic        halt,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        halted_q, halted_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    halted_d      = halted_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A taken branch wins over everything: the jump, halt and stall seen
        // this cycle all come from wrong-path instructions.
        if (br_taken) begin
          pc_d          = br_target & ALIGN_MASK;
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0;
        end else if (jmp) begin
          pc_d          = jmp_target & ALIGN_MASK;
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0;
        end else if (halt) begin
          state_d       = ST_HALT;
          halted_d      = 1'b1;
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0;
        end else if (!stall) begin
          pc_d          = pc_plus4;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_plus4;
          if_id_instr_d = instr;
          if_id_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        if_id_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;

`ifdef IF_BUBBLE_COUNT_EN
  logic        bubble;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Any control input in RUN yields either a flush, halt entry or a stall hold.
  assign bubble = (state_q == ST_RUN) && (br_taken || jmp || halt || stall);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule

`default_nettype wire
